// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris game controller: state encoding, collision
// check opcodes, key codes and board geometry.
package tetris_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_SPAWN = 4'd1,
    ST_WAIT  = 4'd2,
    ST_CHECK = 4'd3,
    ST_APPLY = 4'd4,
    ST_LOCK  = 4'd5,
    ST_CLEAR = 4'd6,
    ST_SCORE = 4'd7,
    ST_OVER  = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_CW    = 3'd1,
    OP_CCW   = 3'd2,
    OP_LEFT  = 3'd3,
    OP_RIGHT = 3'd4,
    OP_DOWN  = 3'd5,
    OP_SPAWN = 3'd7
  } chk_op_t;

  localparam logic [2:0] KEY_RESTART = 3'd1;
  localparam logic [2:0] KEY_DROP    = 3'd2;
  localparam logic [2:0] KEY_CW      = 3'd3;
  localparam logic [2:0] KEY_CCW     = 3'd4;
  localparam logic [2:0] KEY_LEFT    = 3'd5;
  localparam logic [2:0] KEY_RIGHT   = 3'd6;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int SPAWN_X = 6;
  localparam int SPAWN_Y = 24;

  // Keys that are queued for WAIT; restart is acted on directly, 0 and 7 are ignored.
  function automatic logic is_move_key(input logic [2:0] code);
    is_move_key = (code >= KEY_DROP) && (code <= KEY_RIGHT);
  endfunction

  function automatic chk_op_t key_to_op(input logic [2:0] code);
    case (code)
      KEY_CW:    key_to_op = OP_CW;
      KEY_CCW:   key_to_op = OP_CCW;
      KEY_LEFT:  key_to_op = OP_LEFT;
      KEY_RIGHT: key_to_op = OP_RIGHT;
      default:   key_to_op = OP_DOWN;
    endcase
  endfunction

endpackage

// File: rtl/tetris_input_buf.sv
// One-entry key buffer plus the gravity tick divider and its pending flag.
module tetris_input_buf
  import tetris_pkg::*;
#(
  parameter int GRAVITY_TICKS = 100,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       key_valid,
  input  logic [2:0] key_code,
  input  logic       tick,
  input  logic       cnt_en,
  input  logic       consume,
  input  logic       pend_clr,
  output logic       buf_valid,
  output logic [2:0] buf_code,
  output logic       grav_pending
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(GRAVITY_TICKS - 1);

  logic [CNT_W-1:0] grav_cnt;
  logic             wrap;

  assign wrap = tick && cnt_en && (grav_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid    <= 1'b0;
      buf_code     <= 3'd0;
      grav_cnt     <= '0;
      grav_pending <= 1'b0;
    end else if (flush) begin
      buf_valid    <= 1'b0;
      grav_cnt     <= '0;
      grav_pending <= 1'b0;
    end else begin
      // A key arriving while the entry is occupied (even in the consume cycle) is lost.
      if (consume) begin
        buf_valid <= 1'b0;
      end else if (!buf_valid && key_valid && is_move_key(key_code)) begin
        buf_valid <= 1'b1;
        buf_code  <= key_code;
      end
      if (tick && cnt_en) begin
        grav_cnt <= wrap ? '0 : grav_cnt + CNT_W'(1);
      end
      if (wrap) begin
        grav_pending <= 1'b1;
      end else if (pend_clr) begin
        grav_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tetris_game_ctrl.sv
// Game sequencer: spawn, move/rotate, gravity, hard drop, lock, row clearing,
// scoring and game-over, sharing one collision checker and one row eliminator.
module tetris_game_ctrl
  import tetris_pkg::*;
#(
  parameter int GRAVITY_TICKS = 100,
  parameter int CNT_W         = 8,
  parameter int MAX_CLEAR     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       key_valid,
  input  logic [2:0] key_code,
  output logic       chk_req,
  output logic [2:0] chk_op,
  input  logic       chk_ack,
  input  logic       chk_ok,
  output logic       apply,
  output logic       lock,
  output logic       clr_board,
  output logic       row_req,
  input  logic       row_ack,
  input  logic       row_hit,
  output logic       score_hit,
  output logic [2:0] lines,
  output logic       game_over,
  output logic [3:0] state
);

  localparam logic [2:0] MAX_C = 3'(MAX_CLEAR);

  state_t     state_q, state_d;
  chk_op_t    op_q, op_d;
  logic       drop_q, drop_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] lines_q, lines_d;
  logic       row_gap_q, row_gap_d;

  logic       restart;
  logic       buf_valid;
  logic [2:0] buf_code;
  logic       grav_pending;
  logic       consume;
  logic       grav_take;
  logic       cnt_en;
  logic       pend_clr;

  assign restart  = key_valid && (key_code == KEY_RESTART);
  assign cnt_en   = state_q inside {ST_WAIT, ST_CHECK, ST_APPLY, ST_CLEAR};
  assign pend_clr = grav_take || ((state_d == ST_SPAWN) && (state_q != ST_SPAWN));

  tetris_input_buf #(
    .GRAVITY_TICKS(GRAVITY_TICKS),
    .CNT_W        (CNT_W)
  ) u_input_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (restart),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .tick        (tick),
    .cnt_en      (cnt_en),
    .consume     (consume),
    .pend_clr    (pend_clr),
    .buf_valid   (buf_valid),
    .buf_code    (buf_code),
    .grav_pending(grav_pending)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NONE;
      drop_q    <= 1'b0;
      cnt_q     <= 3'd0;
      lines_q   <= 3'd0;
      row_gap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      lines_q   <= lines_d;
      row_gap_q <= row_gap_d;
    end
  end

  // Handshakes: a request is held with a stable opcode until ack is seen high
  // in a cycle where the request is high; it is low in the following cycle.
  // Ack while the request is low is ignored. A restart key drops any request
  // in its own cycle and wins over a simultaneous ack.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    lines_d   = lines_q;
    row_gap_d = 1'b0;
    consume   = 1'b0;
    grav_take = 1'b0;
    chk_req   = 1'b0;
    row_req   = 1'b0;
    apply     = 1'b0;
    lock      = 1'b0;
    clr_board = 1'b0;
    score_hit = 1'b0;

    if (restart) begin
      clr_board = 1'b1;
      state_d   = ST_SPAWN;
      op_d      = OP_SPAWN;
      drop_d    = 1'b0;
      cnt_d     = 3'd0;
    end else begin
      case (state_q)
        ST_SPAWN: begin
          chk_req = 1'b1;
          if (chk_ack) state_d = chk_ok ? ST_APPLY : ST_OVER;
        end
        ST_WAIT: begin
          if (buf_valid) begin
            consume = 1'b1;
            state_d = ST_CHECK;
            op_d    = key_to_op(buf_code);
            drop_d  = (buf_code == KEY_DROP);
          end else if (grav_pending) begin
            grav_take = 1'b1;
            state_d   = ST_CHECK;
            op_d      = OP_DOWN;
          end
        end
        ST_CHECK: begin
          chk_req = 1'b1;
          if (chk_ack) begin
            if (chk_ok) begin
              state_d = ST_APPLY;
            end else if (op_q == OP_DOWN) begin
              state_d = ST_LOCK;
              drop_d  = 1'b0;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
        ST_APPLY: begin
          apply   = 1'b1;
          state_d = drop_q ? ST_CHECK : ST_WAIT;
        end
        ST_LOCK: begin
          lock    = 1'b1;
          cnt_d   = 3'd0;
          state_d = ST_CLEAR;
        end
        ST_CLEAR: begin
          // row_gap_q forces one idle cycle between consecutive row requests.
          row_req = !row_gap_q;
          if (!row_gap_q && row_ack) begin
            if (row_hit) cnt_d = cnt_q + 3'd1;
            if (row_hit && ((cnt_q + 3'd1) < MAX_C)) row_gap_d = 1'b1;
            else                                     state_d   = ST_SCORE;
          end
        end
        ST_SCORE: begin
          lines_d   = cnt_q;
          score_hit = (cnt_q != 3'd0);
          state_d   = ST_SPAWN;
          op_d      = OP_SPAWN;
        end
        default: ;
      endcase
    end
  end

  assign chk_op    = (state_q inside {ST_SPAWN, ST_CHECK, ST_APPLY}) ? op_q : OP_NONE;
  assign lines     = lines_q;
  assign game_over = (state_q == ST_OVER);
  assign state     = state_q;

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Bench for tetris_game_ctrl: directed scenarios plus random play, checked
// every cycle against a rule-level model and pinned by literal expectations.
module tb_tetris_game_ctrl;

  localparam int GT   = 3;
  localparam int MAXC = 4;

  localparam int S_IDLE = 0, S_SPAWN = 1, S_WAIT = 2, S_CHECK = 3, S_APPLY = 4;
  localparam int S_LOCK = 5, S_CLEAR = 6, S_SCORE = 7, S_OVER = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic       key_valid = 1'b0;
  logic [2:0] key_code = 3'd0;
  logic       chk_ack = 1'b0, chk_ok = 1'b0, row_ack = 1'b0, row_hit = 1'b0;
  logic       chk_req, apply, lock, clr_board, row_req, score_hit, game_over;
  logic [2:0] chk_op, lines;
  logic [3:0] state;

  always #5 clk = ~clk;

  tetris_game_ctrl #(.GRAVITY_TICKS(GT), .CNT_W(8), .MAX_CLEAR(MAXC)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .key_valid(key_valid), .key_code(key_code),
    .chk_req(chk_req), .chk_op(chk_op), .chk_ack(chk_ack), .chk_ok(chk_ok),
    .apply(apply), .lock(lock), .clr_board(clr_board), .row_req(row_req),
    .row_ack(row_ack), .row_hit(row_hit), .score_hit(score_hit), .lines(lines),
    .game_over(game_over), .state(state)
  );

  int checks = 0;
  int failures = 0;

  // Rule-level model of the game sequencer.
  int m_st, m_op, m_cnt, m_lines, m_gcnt, m_code;
  bit m_drop, m_bufv, m_pend, m_gap;

  // Pulse / handshake counters observed from the DUT.
  int n_apply, n_apply_down, n_lock, n_clr, n_score, n_row_hs, n_down_hs, n_ok_down, n_spawn_cyc;
  logic [2:0] exp_q[$];
  bit sb_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_op = 0; m_cnt = 0; m_lines = 0; m_gcnt = 0; m_code = 0;
    m_drop = 0; m_bufv = 0; m_pend = 0; m_gap = 0;
  endtask

  task automatic zero_counts();
    n_apply = 0; n_apply_down = 0; n_lock = 0; n_clr = 0; n_score = 0;
    n_row_hs = 0; n_down_hs = 0; n_ok_down = 0; n_spawn_cyc = 0;
  endtask

  task automatic model_compare();
    bit rs;
    int e_op;
    rs = key_valid && (key_code == 3'd1);
    e_op = (m_st == S_SPAWN) ? 7 : ((m_st == S_CHECK || m_st == S_APPLY) ? m_op : 0);
    check("state", int'(state), m_st);
    check("chk_req", int'(chk_req), int'(!rs && (m_st == S_SPAWN || m_st == S_CHECK)));
    check("chk_op", int'(chk_op), e_op);
    check("apply", int'(apply), int'(!rs && m_st == S_APPLY));
    check("lock", int'(lock), int'(!rs && m_st == S_LOCK));
    check("clr_board", int'(clr_board), int'(rs));
    check("row_req", int'(row_req), int'(!rs && m_st == S_CLEAR && !m_gap));
    check("score_hit", int'(score_hit), int'(!rs && m_st == S_SCORE && m_cnt > 0));
    check("lines", int'(lines), m_lines);
    check("game_over", int'(game_over), int'(m_st == S_OVER));
  endtask

  task automatic model_step();
    bit rs, wrap, take, key_ok, had_buf;
    int nst;
    rs = key_valid && (key_code == 3'd1);
    if (rs) begin
      m_st = S_SPAWN; m_op = 7; m_drop = 0; m_cnt = 0; m_bufv = 0;
      m_gcnt = 0; m_pend = 0; m_gap = 0;
      return;
    end
    wrap = 0;
    if (tick && (m_st == S_WAIT || m_st == S_CHECK || m_st == S_APPLY || m_st == S_CLEAR)) begin
      m_gcnt++;
      if (m_gcnt == GT) begin m_gcnt = 0; wrap = 1; end
    end
    had_buf = m_bufv; take = 0; nst = m_st;
    key_ok = key_valid && key_code >= 3'd2 && key_code <= 3'd6;
    case (m_st)
      S_SPAWN: if (chk_ack) nst = chk_ok ? S_APPLY : S_OVER;
      S_WAIT: begin
        if (m_bufv) begin
          m_bufv = 0; nst = S_CHECK;
          if (m_code == 2) begin m_op = 5; m_drop = 1; end
          else m_op = m_code - 2;
        end else if (m_pend) begin
          take = 1; nst = S_CHECK; m_op = 5;
        end
      end
      S_CHECK: if (chk_ack) begin
        if (chk_ok) nst = S_APPLY;
        else if (m_op == 5) begin nst = S_LOCK; m_drop = 0; end
        else nst = S_WAIT;
      end
      S_APPLY: nst = m_drop ? S_CHECK : S_WAIT;
      S_LOCK: begin m_cnt = 0; nst = S_CLEAR; end
      S_CLEAR: begin
        if (m_gap) m_gap = 0;
        else if (row_ack) begin
          if (row_hit) m_cnt++;
          if (row_hit && m_cnt < MAXC) m_gap = 1;
          else nst = S_SCORE;
        end
      end
      S_SCORE: begin m_lines = m_cnt; nst = S_SPAWN; m_op = 7; end
      default: ;
    endcase
    if (!had_buf && key_ok) begin m_bufv = 1; m_code = int'(key_code); end
    if (wrap) m_pend = 1;
    else if (take || (nst == S_SPAWN && m_st != S_SPAWN)) m_pend = 0;
    m_st = nst;
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic step();
    #1;
    model_compare();
    if (apply) n_apply++;
    if (apply && chk_op == 3'd5) n_apply_down++;
    if (lock) n_lock++;
    if (clr_board) n_clr++;
    if (score_hit) n_score++;
    if (row_req && row_ack) n_row_hs++;
    if (chk_req && chk_op == 3'd7) n_spawn_cyc++;
    if (chk_req && chk_ack) begin
      if (chk_op == 3'd5) begin
        n_down_hs++;
        if (chk_ok) n_ok_down++;
      end
      if (sb_on) begin
        if (exp_q.size() > 0) check("op_order", int'(chk_op), int'(exp_q.pop_front()));
        else check("extra_check_op", int'(chk_op), 0);
      end
    end
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input logic [2:0] code);
    key_valid = 1'b1; key_code = code;
    step();
    key_valid = 1'b0; key_code = 3'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick = 0; key_valid = 0; key_code = 0;
    chk_ack = 0; chk_ok = 0; row_ack = 0; row_hit = 0;
    model_reset();
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic start_game();
    chk_ack = 1; chk_ok = 1;
    press(3'd1);
    run(3);
  endtask

  initial begin
    int guard;
    @(negedge clk);

    // Reset and first spawn.
    do_reset();
    check("rst_state", int'(state), 0);
    check("rst_chk_req", int'(chk_req), 0);
    check("rst_lines", int'(lines), 0);
    check("rst_game_over", int'(game_over), 0);
    zero_counts();
    chk_ack = 1; chk_ok = 1;
    press(3'd1);
    run(4);
    check("s1_clr_count", n_clr, 1);
    check("s1_apply_count", n_apply, 1);
    check("s1_spawn_req_cycles", n_spawn_cyc, 1);
    check("s1_state", int'(state), 2);
    check("s1_game_over", int'(game_over), 0);

    // Gravity: first down step lands, second locks with no rows.
    zero_counts();
    tick = 1; row_ack = 1; row_hit = 0;
    guard = 0;
    while (!(n_lock == 1 && state == 4'd2) && guard < 100) begin
      chk_ok = (chk_op == 3'd7) || (n_down_hs == 0);
      step();
      guard++;
    end
    tick = 0;
    check("s2_done", int'(guard < 100), 1);
    check("s2_down_checks", n_down_hs, 2);
    check("s2_down_applies", n_apply_down, 1);
    check("s2_locks", n_lock, 1);
    check("s2_score_hits", n_score, 0);
    check("s2_lines", int'(lines), 0);
    check("s2_spawns", n_spawn_cyc, 1);

    // Hard drop: five good down steps, then lock and four full rows.
    do_reset();
    start_game();
    zero_counts();
    row_ack = 1; row_hit = 1;
    press(3'd2);
    guard = 0;
    begin
      int wait_mid;
      wait_mid = 0;
      while (!(n_score == 1 && state == 4'd2) && guard < 100) begin
        chk_ok = (chk_op == 3'd7) || (n_ok_down < 5);
        step();
        if (n_down_hs > 0 && n_lock == 0 && state == 4'd2) wait_mid++;
        guard++;
      end
      check("s3_done", int'(guard < 100), 1);
      check("s3_wait_between", wait_mid, 0);
    end
    check("s3_down_applies", n_apply_down, 5);
    check("s3_down_checks", n_down_hs, 6);
    check("s3_locks", n_lock, 1);
    check("s3_row_handshakes", n_row_hs, 4);
    check("s3_lines", int'(lines), 4);
    check("s3_score_hits", n_score, 1);

    // Key left coincides with the gravity wrap; a second key during CHECK is lost.
    do_reset();
    row_ack = 0; row_hit = 0;
    start_game();
    zero_counts();
    exp_q = {3'd3, 3'd4, 3'd5};
    sb_on = 1'b1;
    chk_ack = 0;
    tick = 1;
    run(2);
    key_valid = 1; key_code = 3'd5;
    step();
    tick = 0; key_valid = 0; key_code = 0;
    step();
    check("s5_in_check", int'(state), 3);
    press(3'd6);
    press(3'd3);
    run(2);
    chk_ack = 1; chk_ok = 1;
    run(15);
    sb_on = 1'b0;
    check("s5_ops_left", exp_q.size(), 0);
    check("s5_applies", n_apply, 3);

    // Spawn blocked: game over, ticks ignored, restart recovers.
    do_reset();
    zero_counts();
    chk_ack = 1; chk_ok = 0;
    press(3'd1);
    run(2);
    tick = 1;
    run(8);
    tick = 0;
    check("s6_over_state", int'(state), 8);
    check("s6_game_over", int'(game_over), 1);
    check("s6_clr", n_clr, 1);
    zero_counts();
    chk_ok = 1;
    press(3'd1);
    run(3);
    check("s6_restart_clr", n_clr, 1);
    check("s6_restart_state", int'(state), 2);
    check("s6_restart_go", int'(game_over), 0);

    // Reset asserted while a check is outstanding.
    chk_ack = 0;
    press(3'd5);
    step();
    #2;
    check("s7_pre_rst_req", int'(chk_req), 1);
    rst_n = 1'b0;
    #1;
    check("s7_rst_req", int'(chk_req), 0);
    check("s7_rst_state", int'(state), 0);
    model_reset();
    @(negedge clk);
    chk_ack = 1; chk_ok = 1;
    step();
    rst_n = 1'b1;
    run(2);
    check("s7_late_ack_idle", int'(state), 0);

    // Random play.
    do_reset();
    start_game();
    for (int i = 0; i < 3000; i++) begin
      tick      = ($urandom_range(0, 3) == 0);
      key_valid = ($urandom_range(0, 5) == 0);
      key_code  = 3'($urandom_range(0, 7));
      if (key_code == 3'd1 && $urandom_range(0, 3) != 0) key_code = 3'd2;
      chk_ack   = ($urandom_range(0, 1) == 1);
      chk_ok    = ($urandom_range(0, 7) != 0);
      row_ack   = ($urandom_range(0, 1) == 1);
      row_hit   = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
